// File: rtl/imem_loader.sv
// Boot-time IM loader: framed byte stream to 32-bit big-endian IM writes.
// Holds the CPU stopped until the final word has been committed.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;

  logic              acc;
  logic [16:0]       n_hdr;
  logic [31:0]       word;

  assign in_ready = !rst && (state_q == S_HDR0 ||
                             state_q == S_HDR1 ||
                             state_q == S_DATA);
  assign acc   = in_valid && in_ready;
  assign n_hdr = {1'b0, hdr_hi_q, in_data};
  assign word  = {asm_q, in_data};

  always_comb begin
    state_d  = state_q;
    hdr_hi_d = hdr_hi_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    asm_d    = asm_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    csum_d   = csum_q;
    // Release lags DONE by a cycle so the last IM write lands first.
    done_d   = done_q | (state_q == S_DONE);
    run_d    = run_q | (state_q == S_DONE);
    if (acc) begin
      unique case (state_q)
        S_HDR0: begin
          hdr_hi_d = in_data;
          state_d  = S_HDR1;
        end
        S_HDR1: begin
          if (n_hdr == 17'd0) begin
            state_d = S_DONE;
          end else if (n_hdr > 17'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            cnt_d   = n_hdr[ADDR_W:0];
            widx_d  = '0;
            bidx_d  = '0;
          end
        end
        S_DATA: begin
          asm_d  = word[23:0];
          csum_d = csum_q + in_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = word;
            widx_d  = widx_q + (ADDR_W+1)'(1);
            if (widx_d == cnt_q) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HDR0;
      hdr_hi_q <= '0;
      cnt_q    <= '0;
      widx_q   <= '0;
      bidx_q   <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      hdr_hi_q <= hdr_hi_d;
      cnt_q    <= cnt_d;
      widx_q   <= widx_d;
      bidx_q   <= bidx_d;
      asm_q    <= asm_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      run_q    <= run_d;
      done_q   <= done_d;
      err_q    <= err_d;
      csum_q   <= csum_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_run  = run_q;
  assign done     = done_q;
  assign err      = err_q;
  assign checksum = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a frame-level model.
// Writes are logged by a monitor and compared with expected words.
module tb_imem_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_run;
  logic          done;
  logic          err;
  logic [7:0]    checksum;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_run  (cpu_run),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int last_acc = 0;

  logic [AW+31:0] wq[$];
  logic [7:0]     pay [0:1023];

  always @(negedge clk) if (im_we) wq.push_back({im_addr, im_wdata});

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries = 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    last_acc = cyc + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_csum", checksum, 0);
  endtask

  task automatic run_frame(input int n, input int maxgap);
    logic [31:0] w;
    int sum = 0;
    wq.delete();
    send_byte(8'(n >> 8), int'($urandom_range(maxgap, 0)));
    send_byte(8'(n), int'($urandom_range(maxgap, 0)));
    for (int i = 0; i < 4 * n; i++)
      send_byte(pay[i], int'($urandom_range(maxgap, 0)));
    @(negedge clk);
    in_valid = 1'b0;
    chk("done_early", done, 0);
    chk("run_early", cpu_run, 0);
    chk("ready_in_done", in_ready, 0);
    @(negedge clk);
    chk("done", done, 1);
    chk("cpu_run", cpu_run, 1);
    repeat (2) @(negedge clk);
    chk("n_writes", wq.size(), n);
    for (int k = 0; k < n; k++) begin
      w = {pay[4*k], pay[4*k+1], pay[4*k+2], pay[4*k+3]};
      if (k < wq.size()) chk("write", wq[k], {AW'(k), w});
    end
    for (int i = 0; i < 4 * n; i++) sum += int'(pay[i]);
    chk("checksum", checksum, sum % 256);
    chk("no_err", err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sz;
    int bad;
    logic [7:0] cs;

    do_reset();

    // directed two-word frame
    {pay[0], pay[1], pay[2], pay[3]} = 32'h20080005;
    {pay[4], pay[5], pay[6], pay[7]} = 32'h00000000;
    run_frame(2, 0);
    chk("csum_2d", checksum, 8'h2D);

    // bytes after completion are refused
    sz = wq.size();
    cs = checksum;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      if (in_ready || im_we) bad++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_done_ready", bad, 0);
    chk("post_done_writes", wq.size(), sz);
    chk("post_done_csum", checksum, cs);
    chk("post_done_done", done, 1);

    // empty frame
    do_reset();
    run_frame(0, 0);

    // oversized header
    do_reset();
    wq.delete();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_set", err, 1);
    chk("err_ready", in_ready, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      if (in_ready || cpu_run || done) bad++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_hold", bad, 0);
    chk("err_sticky", err, 1);
    chk("err_no_write", wq.size(), 0);

    // reset mid-load, then a fresh frame
    do_reset();
    wq.delete();
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_writes", wq.size(), 1);
    if (wq.size() > 0)
      chk("pre_rst_word", wq[0],
          {AW'(0), pay[0], pay[1], pay[2], pay[3]});
    do_reset();
    {pay[0], pay[1], pay[2], pay[3]} = 32'hDEADBEEF;
    run_frame(1, 0);
    chk("csum_38", checksum, 8'h38);
    if (wq.size() > 0) chk("deadbeef", wq[0], {AW'(0), 32'hDEADBEEF});

    // randomized frames with idle gaps
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < 24; i++) pay[i] = 8'($urandom);
      run_frame(int'($urandom_range(6, 1)), 5);
    end

    // full-capacity frame
    do_reset();
    for (int i = 0; i < 4 * DEPTH; i++) pay[i] = 8'($urandom);
    run_frame(DEPTH, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the multi-cycle CPU's instruction memory (`IM`). It accepts a framed byte stream and assembles big-endian 32-bit instruction words. It writes them sequentially into the IM write port while holding the CPU stopped, then releases it. This replaces the simulation-only `$readmemh` preload with a synthesizable path usable by both the bench and FPGA bring-up.

## Interface
Parameters:
- `ADDR_W`, default 8: IM word-address width; capacity `DEPTH = 2**ADDR_W` words.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data` holds a byte.
- `in_data`, input, 8: stream byte.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `im_we`, output, 1: one-cycle IM write strobe.
- `im_addr`, output, ADDR_W: IM word address.
- `im_wdata`, output, 32: IM write data.
- `cpu_run`, output, 1: 0 holds the CPU stopped; 1 lets it run. This drives the CPU's run/reset-release input.
- `done`, output, 1: load completed successfully (sticky).
- `err`, output, 1: header count exceeded DEPTH (sticky).
- `checksum`, output, 8: mod-256 sum of all accepted payload bytes (header excluded).

## Operation
- Frame format: 2 header bytes giving word count N (16-bit, MSB first), then 4·N payload bytes. Each word is sent MSB first.
- A byte transfers on a rising edge where `in_valid && in_ready`.
- FSM states:
  - HDR0: capture N[15:8], go to HDR1.
  - HDR1: capture N[7:0]. If N==0, go to DONE. If N>DEPTH, go to ERR. Otherwise go to DATA with word index 0 and byte index 0.
  - DATA: shift the byte into a 32-bit assembler. On the 4th byte, issue the write, increment the word index, and reset the byte index. Go to DONE after word N-1.
  - DONE: terminal until `rst`.
  - ERR: terminal until `rst`.
- `in_ready` is 1 only in HDR0, HDR1 and DATA, and 0 while `rst` is high. It does not depend on `in_valid`.
- Word index counter is ADDR_W+1 bits wide so N==DEPTH is legal. Last address written is DEPTH-1; no wrap.
- `checksum` adds every payload byte mod 256, and updates in the cycle after acceptance.
- Bytes presented in DONE/ERR are not accepted; `in_ready`=0 and there is no state change.
- Mid-load `rst`: state returns to HDR0, and the assembler, counters and `checksum` clear. IM keeps any words already written; partially assembled words are discarded.

## Timing
- Reset values (cycle after an edge with `rst`=1): state HDR0, `in_ready`=1 once `rst` is low, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_run`=0, `done`=0, `err`=0, `checksum`=0.
- All outputs except `in_ready` are registered.
- Word write: the 4th byte of word k is accepted at edge t. In cycle t+1, `im_we`=1, `im_addr`=k and `im_wdata`=the assembled word. `im_we` drops in t+2 unless another write follows.
- `im_addr` and `im_wdata` hold their last values when `im_we`=0.
- Completion: the final payload byte is accepted at edge t. The state is DONE and `in_ready`=0 in cycle t+1, when the last `im_we` is high. `done`=1 and `cpu_run`=1 from cycle t+2, so the CPU never fetches before the last IM write commits.
- N==0: HDR1 byte accepted at edge t; `done`=`cpu_run`=1 from t+2. No `im_we`.
- N>DEPTH: HDR1 byte accepted at edge t; `err`=1 from t+1. `cpu_run` stays 0 and `done` stays 0.
- Throughput: one byte per cycle sustained, i.e. one IM write per 4 cycles.
- `in_valid` gaps stall progress with no effect on the assembled data.
- `cpu_run`, `done` and `err` change only via FSM completion or `rst`.

## Test plan
- Header 0x0002, payload 0x20,0x08,0x00,0x05, 0x00,0x00,0x00,0x00 at full rate:
  - `im_we` pulses: addr 0 data 0x20080005, then addr 1 data 0x00000000.
  - `checksum`=0x2D.
  - `done`=`cpu_run`=1 exactly 2 cycles after the last byte.
- Header 0x0000: no `im_we`, `done`=1 two cycles after the 2nd byte, `checksum`=0.
- ADDR_W=8, header 0x0101 (257): `err`=1 one cycle after the 2nd byte. `in_ready`=0 thereafter; `cpu_run` stays 0 for 20 further valid bytes.
- Header 0x0001, payload bytes with randomized `in_valid` gaps (0–5 idle cycles): single write of the correct word. No extra `im_we` during gaps.
- Header 0x0002, 6 payload bytes, then `rst` for 1 cycle, then a fresh frame 0x0001 + 0xDEADBEEF:
  - First word at addr 0 written pre-reset.
  - Post-reset write: addr 0 data 0xDEADBEEF, `checksum`=0x38, `done`=1.
- After `done`, hold `in_valid`=1 with 0xFF for 10 cycles: `in_ready`=0, no `im_we`, `checksum` unchanged.
